// File: rtl/msg_sequencer.sv
// Sequences a two-message character ROM onto a valid/ready display port,
// with programmable inter-character pacing, loop and abort control.
module msg_sequencer #(
  parameter int unsigned LEN0   = 126,
  parameter int unsigned LEN1   = 77,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sel,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [DIV_W-1:0]  pace_div,
  output logic              rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              msg_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(LEN0 - 1);
  localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(LEN1 - 1);

  logic [2:0]        state_q, state_d;
  logic              rom_sel_q, rom_sel_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        char_data_q, char_data_d;
  logic              char_valid_q, char_valid_d;
  logic              busy_q, busy_d;
  logic              msg_done_q, msg_done_d;
  logic [DIV_W-1:0]  gap_q, gap_d;

  logic [ADDR_W-1:0] last_addr;
  logic              xfer;

  assign last_addr = rom_sel_q ? LAST1 : LAST0;
  assign xfer      = char_valid_q & char_ready;

  always_comb begin
    state_d      = state_q;
    rom_sel_d    = rom_sel_q;
    rom_addr_d   = rom_addr_q;
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    msg_done_d   = 1'b0;
    gap_d        = gap_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d    = S_FETCH;
          rom_sel_d  = sel[1] ^ sel[0];
          rom_addr_d = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        char_data_d  = rom_data;
        char_valid_d = 1'b1;
        state_d      = S_PRESENT;
      end
      S_PRESENT: begin
        if (xfer) begin
          char_valid_d = 1'b0;
          gap_d        = pace_div;
          if (rom_addr_q == last_addr) begin
            msg_done_d = 1'b1;
            if (loop) begin
              rom_addr_d = '0;
              rom_sel_d  = sel[1] ^ sel[0];
              state_d    = S_GAP;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_FETCH;
        end else begin
          gap_d = gap_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a transfer on the same edge.
    if (stop && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      char_valid_d = 1'b0;
      msg_done_d   = 1'b0;
      rom_sel_d    = rom_sel_q;
      rom_addr_d   = rom_addr_q;
      gap_d        = gap_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rom_sel_q    <= 1'b0;
      rom_addr_q   <= '0;
      char_data_q  <= '0;
      char_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      msg_done_q   <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      rom_sel_q    <= rom_sel_d;
      rom_addr_q   <= rom_addr_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      busy_q       <= busy_d;
      msg_done_q   <= msg_done_d;
      gap_q        <= gap_d;
    end
  end

  assign rom_sel    = rom_sel_q;
  assign rom_addr   = rom_addr_q;
  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign busy       = busy_q;
  assign msg_done   = msg_done_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// Scoreboard bench for msg_sequencer: expected characters are queued at
// stimulus time and consumed by an independent transfer monitor.
module tb_msg_sequencer;

  localparam int unsigned LEN0 = 126;
  localparam int unsigned LEN1 = 77;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [15:0] pace_div = 16'd0;
  logic       rom_sel;
  logic [6:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready = 1'b0;
  logic       busy;
  logic       msg_done;

  msg_sequencer #(.LEN0(LEN0), .LEN1(LEN1), .ADDR_W(7), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .sel(sel), .start(start), .stop(stop),
    .loop(loop), .pace_div(pace_div), .rom_sel(rom_sel), .rom_addr(rom_addr),
    .rom_data(rom_data), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic m, input logic [6:0] a);
    int v;
    v = int'(a) * 37 + (m ? 113 : 5);
    return 8'(v ^ (int'(a) << 1));
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_sel, rom_addr);

  typedef struct {
    logic        m;
    int unsigned idx;
    logic [7:0]  d;
    bit          last;
  } item_t;

  item_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int run_id = 0;
  int per_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_msg(input logic m);
    int unsigned len;
    item_t it;
    len = m ? LEN1 : LEN0;
    for (int unsigned i = 0; i < len; i++) begin
      it.m = m;
      it.idx = i;
      it.d = rom_fn(m, 7'(i));
      it.last = (i == len - 1);
      exp_q.push_back(it);
    end
  endtask

  // Monitor: every accepted character must match the head of the queue.
  item_t mon_it;
  int cyc = 0;
  int last_cyc = 0;
  int last_run = -1;
  bit done_exp = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      done_exp = 1'b0;
    end else begin
      check("msg_done", 32'(msg_done), 32'(done_exp));
      done_exp = 1'b0;
      if (char_valid && char_ready && !stop) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 32'(char_valid), 32'd0);
        end else begin
          mon_it = exp_q.pop_front();
          check("xfer_rom_sel", 32'(rom_sel), 32'(mon_it.m));
          check("xfer_rom_addr", 32'(rom_addr), mon_it.idx);
          check("xfer_char_data", 32'(char_data), 32'(mon_it.d));
          done_exp = mon_it.last;
          if (per_exp != 0 && last_run == run_id)
            check("xfer_period", 32'(cyc - last_cyc), 32'(per_exp));
          last_cyc = cyc;
          last_run = run_id;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input bit rnd_ready);
    int n;
    n = 0;
    do begin
      tick();
      if (rnd_ready) char_ready = 1'($urandom_range(0, 1));
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    check("idle_reached", ((busy || exp_q.size() != 0) ? 32'd1 : 32'd0), 32'd0);
    char_ready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int seen_done;
    bit switched;
    logic rm;

    #2 reset = 1'b1;
    #1;
    check("rst_rom_sel", 32'(rom_sel), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_char_data", 32'(char_data), 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_msg_done", 32'(msg_done), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Start latency, then asynchronous reset while a character is presented.
    sel = 2'b00;
    char_ready = 1'b0;
    pulse_start();
    check("lat_e0_busy", 32'(busy), 32'd1);
    check("lat_e0_valid", 32'(char_valid), 32'd0);
    tick();
    check("lat_e1_valid", 32'(char_valid), 32'd0);
    tick();
    check("lat_e2_valid", 32'(char_valid), 32'd1);
    check("lat_e2_addr", 32'(rom_addr), 32'd0);
    check("lat_e2_data", 32'(char_data), 32'(rom_fn(1'b0, 7'd0)));
    #3 reset = 1'b1;
    #1;
    check("arst_valid", 32'(char_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(rom_addr), 32'd0);
    check("arst_data", 32'(char_data), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // One-shot message 0, unpaced.
    char_ready = 1'b1;
    sel = 2'b00; loop = 1'b0; pace_div = 16'd0;
    run_id++; per_exp = 4;
    push_msg(1'b0);
    pulse_start();
    run_until_idle(2000, 1'b0);
    check("oneshot_busy", 32'(busy), 32'd0);

    // Backpressure on character 5 of message 1.
    sel = 2'b01; per_exp = 0; run_id++;
    push_msg(1'b1);
    pulse_start();
    for (int i = 0; i < 200 && rom_addr != 7'd5; i++) tick();
    char_ready = 1'b0;
    for (int i = 0; i < 20 && !char_valid; i++) tick();
    check("bp_valid_seen", 32'(char_valid), 32'd1);
    held = char_data;
    check("bp_data_first", 32'(held), 32'(rom_fn(1'b1, 7'd5)));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_hold", 32'(char_valid), 32'd1);
      check("bp_data_hold", 32'(char_data), 32'(held));
      check("bp_addr_hold", 32'(rom_addr), 32'd5);
    end
    char_ready = 1'b1;
    run_until_idle(2000, 1'b0);

    // Pacing of 3 extra cycles on message 1 (sel=10).
    sel = 2'b10; pace_div = 16'd3; per_exp = 7; run_id++;
    push_msg(1'b1);
    pulse_start();
    run_until_idle(2000, 1'b0);

    // Loop with a select change mid-message; stop after the second message.
    sel = 2'b00; pace_div = 16'd0; loop = 1'b1; per_exp = 4; run_id++;
    push_msg(1'b0);
    pulse_start();
    seen_done = 0;
    switched = 1'b0;
    for (int i = 0; i < 3000 && seen_done < 2; i++) begin
      tick();
      if (rom_addr == 7'd40 && !switched) begin
        sel = 2'b10;
        push_msg(1'b1);
        switched = 1'b1;
      end
      if (msg_done) seen_done++;
    end
    check("loop_done_count", 32'(seen_done), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    check("loop_stop_busy", 32'(busy), 32'd0);
    check("loop_stop_valid", 32'(char_valid), 32'd0);
    check("loop_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Abort during the gap after character 10, then restart.
    sel = 2'b00; pace_div = 16'd2; per_exp = 6; run_id++;
    push_msg(1'b0);
    pulse_start();
    for (int i = 0; i < 200 && !(rom_addr == 7'd11 && !char_valid && busy); i++) tick();
    check("abort_in_gap_addr", 32'(rom_addr), 32'd11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(char_valid), 32'd0);
    check("abort_msg_done", 32'(msg_done), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_stays_idle", 32'(busy), 32'd0);
    end
    run_id++;
    push_msg(1'b0);
    pulse_start();
    check("restart_addr", 32'(rom_addr), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    run_until_idle(3000, 1'b0);

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("start_stop_idle", 32'(busy), 32'd0);
    end
    start = 1'b0; stop = 1'b0;

    // Randomized runs with random backpressure and pacing.
    per_exp = 0;
    for (int r = 0; r < 6; r++) begin
      sel = 2'($urandom_range(0, 3));
      pace_div = 16'($urandom_range(0, 4));
      rm = sel[1] ^ sel[0];
      run_id++;
      push_msg(rm);
      char_ready = 1'($urandom_range(0, 1));
      pulse_start();
      run_until_idle(6000, 1'b1);
    end

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
